// File: rtl/gpio_rx_pkg.sv
// gpio_rx_pkg: shared state encoding and pin/flag bit offsets for the GPIO frame receiver.
package gpio_rx_pkg;
  typedef enum logic [2:0] {IDLE, HEADER_DONE, PAYLOAD, CHECK, DELIVER} state_t;
  // Offsets below DATA_W for header flags, above DATA_W for the strobe pins
  localparam int TEXT_FLAG_OFS = 1;
  localparam int AUDIO_FLAG_OFS = 2;
  localparam int RX_CLOCK_OFS = 1;
  localparam int RX_VALID_OFS = 0;
endpackage

// File: rtl/gpio_frame_receiver_if.sv
// gpio_frame_receiver_if: GPIO pin bundle in, delivered text/audio frame out.
interface gpio_frame_receiver_if #(
  parameter int DATA_W = 16,
  parameter int TEXT_W = 8,
  parameter int AUDIO_W = 32
);
  logic [DATA_W+1:0] rx_pins;
  logic [TEXT_W-1:0] text_out;
  logic text_ready_out;
  logic [AUDIO_W-1:0] audio_out;
  logic audio_ready_out;
  logic frame_valid;
  logic frame_error;
  modport master (output rx_pins, input text_out, text_ready_out, audio_out, audio_ready_out, frame_valid, frame_error);
  modport slave (input rx_pins, output text_out, text_ready_out, audio_out, audio_ready_out, frame_valid, frame_error);
endinterface

// File: rtl/gpio_rx_sync.sv
// gpio_rx_sync: multi-flop synchroniser on rx_pins plus rx_clock rising-edge beat strobe.
module gpio_rx_sync
  import gpio_rx_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              FPGA_clock,
  input  logic              reset,
  input  logic [DATA_W+1:0] rx_pins,
  output logic [DATA_W-1:0] data,
  output logic              rx_valid,
  output logic              beat
);
  logic [SYNC_STAGES-1:0][DATA_W+1:0] sync_q;
  logic clock_prev;
  logic [DATA_W+1:0] synced;
  assign synced = sync_q[SYNC_STAGES-1];
  assign data = synced[DATA_W-1:0];
  assign rx_valid = synced[DATA_W+RX_VALID_OFS];
  assign beat = synced[DATA_W+RX_CLOCK_OFS] & ~clock_prev;
  always_ff @(posedge FPGA_clock or posedge reset)
    if (reset) begin
      sync_q <= '0;
      clock_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_pins};
      clock_prev <= synced[DATA_W+RX_CLOCK_OFS];
    end
endmodule

// File: rtl/gpio_frame_receiver.sv
// gpio_frame_receiver: assembles header + payload beats into a text/audio frame.
// Define GPIO_RX_PARITY_EN to add a trailing even-parity beat checked in CHECK.
module gpio_frame_receiver
  import gpio_rx_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TEXT_W = 8,
  parameter int AUDIO_W = 32,
  parameter int SYNC_STAGES = 2
) (
  input logic FPGA_clock,
  input logic reset,
  gpio_frame_receiver_if.slave bus
);
  localparam int NBEATS = AUDIO_W / DATA_W;
  localparam int CW = NBEATS > 1 ? $clog2(NBEATS) : 1;
  logic [DATA_W-1:0] data;
  logic rx_valid, beat, start, last;
  state_t state;
  logic prev_valid, text_flag, audio_flag;
  logic [CW-1:0] cnt;
  logic [TEXT_W-1:0] text_q;
  logic [AUDIO_W-1:0] audio_q, audio_nx;
  gpio_rx_sync #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .FPGA_clock(FPGA_clock),
    .reset(reset),
    .rx_pins(bus.rx_pins),
    .data(data),
    .rx_valid(rx_valid),
    .beat(beat)
  );
  assign start = beat & rx_valid & ~prev_valid;
  assign last = cnt == CW'(NBEATS - 1);
  assign audio_nx = (audio_q << DATA_W) | AUDIO_W'(data);
`ifdef GPIO_RX_PARITY_EN
  logic parity;
  assign parity = ^{text_flag, audio_flag, text_q, audio_q};
`endif
  always_ff @(posedge FPGA_clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      prev_valid <= 1'b0;
      cnt <= '0;
      text_flag <= 1'b0;
      audio_flag <= 1'b0;
      text_q <= '0;
      audio_q <= '0;
      bus.text_out <= '0;
      bus.audio_out <= '0;
      bus.text_ready_out <= 1'b0;
      bus.audio_ready_out <= 1'b0;
      bus.frame_valid <= 1'b0;
      bus.frame_error <= 1'b0;
    end else begin
      bus.text_out <= '0;
      bus.audio_out <= '0;
      bus.text_ready_out <= 1'b0;
      bus.audio_ready_out <= 1'b0;
      bus.frame_valid <= 1'b0;
      bus.frame_error <= 1'b0;
      if (beat) prev_valid <= rx_valid;
      if (state == DELIVER) state <= IDLE;
      else if (start) begin
        // A fresh valid edge always wins; a partial frame in flight is dropped
        bus.frame_error <= state != IDLE;
        text_flag <= data[DATA_W-TEXT_FLAG_OFS];
        audio_flag <= data[DATA_W-AUDIO_FLAG_OFS];
        text_q <= data[TEXT_W-1:0];
        cnt <= '0;
        state <= HEADER_DONE;
      end else if (beat && state != IDLE) begin
        if (!rx_valid) begin
          bus.frame_error <= 1'b1;
          state <= IDLE;
        end
`ifdef GPIO_RX_PARITY_EN
        else if (state == CHECK) begin
          if (data[0] == parity) begin
            state <= DELIVER;
            bus.frame_valid <= 1'b1;
            bus.text_out <= text_q & {TEXT_W{text_flag}};
            bus.audio_out <= audio_q & {AUDIO_W{audio_flag}};
            bus.text_ready_out <= text_flag;
            bus.audio_ready_out <= audio_flag;
          end else begin
            bus.frame_error <= 1'b1;
            state <= IDLE;
          end
        end
`endif
        else begin
          audio_q <= audio_nx;
          cnt <= cnt + CW'(1);
          state <= PAYLOAD;
          if (last) begin
`ifdef GPIO_RX_PARITY_EN
            state <= CHECK;
`else
            state <= DELIVER;
            bus.frame_valid <= 1'b1;
            bus.text_out <= text_q & {TEXT_W{text_flag}};
            bus.audio_out <= audio_nx & {AUDIO_W{audio_flag}};
            bus.text_ready_out <= text_flag;
            bus.audio_ready_out <= audio_flag;
`endif
          end
        end
      end
    end
endmodule

// File: tb/tb_gpio_frame_receiver.sv
// tb_gpio_frame_receiver: table-driven frame vectors plus latency and reset sequences.
module tb_gpio_frame_receiver;
`ifdef GPIO_RX_PARITY_EN
  localparam int DW = 8, TW = 6;
`else
  localparam int DW = 16, TW = 8;
`endif
  localparam int AW = 32;
  typedef struct {
    int first, n, ev, ee;
    logic [31:0] et, ea;
    logic etr, ear;
  } vec_t;
  vec_t tbl[$];
  logic [16:0] bq[$];
  logic clk = 1'b0, rst = 1'b1;
  int total = 0, bad = 0, nv = 0, ne = 0, leak = 0;
  logic [TW-1:0] ct = '0;
  logic [AW-1:0] ca = '0;
  logic ctr = 1'b0, car = 1'b0;
  always #5 clk = ~clk;
  gpio_frame_receiver_if #(.DATA_W(DW), .TEXT_W(TW), .AUDIO_W(AW)) bus();
  gpio_frame_receiver #(.DATA_W(DW), .TEXT_W(TW), .AUDIO_W(AW), .SYNC_STAGES(2)) dut (
    .FPGA_clock(clk),
    .reset(rst),
    .bus(bus)
  );
  always @(negedge clk) begin
    if (bus.frame_valid) begin
      nv++;
      ct = bus.text_out;
      ca = bus.audio_out;
      ctr = bus.text_ready_out;
      car = bus.audio_ready_out;
    end
    if (bus.frame_error) ne++;
    if ((bus.frame_valid && bus.frame_error) ||
        (!bus.frame_valid && (bus.text_out != 0 || bus.audio_out != 0 || bus.text_ready_out || bus.audio_ready_out)))
      leak++;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic addv(input int n, input logic [16:0] b0, b1, b2, b3, b4, b5,
                      input int ev, ee, input logic [31:0] et, ea, input logic etr, ear);
    logic [16:0] t[6];
    t = '{b0, b1, b2, b3, b4, b5};
    tbl.push_back('{bq.size(), n, ev, ee, et, ea, etr, ear});
    for (int i = 0; i < n; i++) bq.push_back(t[i]);
  endtask
  task automatic rise(input logic [16:0] w);
    bus.rx_pins = {1'b0, w[16], w[DW-1:0]};
    repeat (4) @(negedge clk);
    bus.rx_pins[DW+1] = 1'b1;
  endtask
  task automatic beat(input logic [16:0] w);
    rise(w);
    repeat (4) @(negedge clk);
    bus.rx_pins[DW+1] = 1'b0;
  endtask
  task automatic latency(input string nm);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.frame_valid && k < 20);
    chk(nm, k, 3);
  endtask
  initial begin
    int b0, e0, l0;
    bus.rx_pins = '0;
`ifdef GPIO_RX_PARITY_EN
    addv(6, 17'h1_00C5, 17'h1_00DE, 17'h1_00AD, 17'h1_00BE, 17'h1_00EF, 17'h1_0000, 1, 0, 32'h05, 32'hDEADBEEF, 1, 1);
    addv(6, 17'h1_00C5, 17'h1_00DE, 17'h1_00AD, 17'h1_00BE, 17'h1_00EF, 17'h1_0001, 0, 1, 0, 0, 0, 0);
    addv(6, 17'h1_0085, 17'h1_0001, 17'h1_0002, 17'h1_0003, 17'h1_0004, 17'h1_0000, 1, 0, 32'h05, 0, 1, 0);
    addv(4, 17'h1_00C5, 17'h1_00DE, 17'h1_00AD, 17'h0_0000, 0, 0, 0, 1, 0, 0, 0, 0);
`else
    addv(3, 17'h1_C041, 17'h1_DEAD, 17'h1_BEEF, 0, 0, 0, 1, 0, 32'h41, 32'hDEADBEEF, 1, 1);
    addv(3, 17'h1_8041, 17'h1_1234, 17'h1_5678, 0, 0, 0, 1, 0, 32'h41, 0, 1, 0);
    addv(3, 17'h1_4041, 17'h1_1234, 17'h1_5678, 0, 0, 0, 1, 0, 0, 32'h12345678, 0, 1);
    addv(3, 17'h1_0041, 17'h1_AAAA, 17'h1_5555, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    addv(3, 17'h1_C041, 17'h1_DEAD, 17'h0_BEEF, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    addv(6, 17'h1_C041, 17'h1_DEAD, 17'h1_BEEF, 17'h1_C0FF, 17'h1_1111, 17'h1_2222, 1, 0, 32'h41, 32'hDEADBEEF, 1, 1);
    addv(3, 17'h1_C0FF, 17'h1_0001, 17'h1_0002, 0, 0, 0, 1, 0, 32'hFF, 32'h00010002, 1, 1);
    addv(5, 17'h1_C041, 17'h0_0000, 17'h1_C042, 17'h1_0000, 17'h1_FFFF, 0, 1, 1, 32'h42, 32'h0000FFFF, 1, 1);
`endif
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.frame_valid, bus.frame_error, bus.text_ready_out, bus.audio_ready_out,
                          |bus.text_out, |bus.audio_out}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int v = 0; v < tbl.size(); v++) begin
      b0 = nv;
      e0 = ne;
      l0 = leak;
      for (int i = 0; i < tbl[v].n; i++) beat(bq[tbl[v].first + i]);
      beat(17'h0);
      repeat (8) @(negedge clk);
      chk($sformatf("v%0d_valid_count", v), nv - b0, tbl[v].ev);
      chk($sformatf("v%0d_error_count", v), ne - e0, tbl[v].ee);
      chk($sformatf("v%0d_idle_outputs", v), leak - l0, 0);
      if (tbl[v].ev != 0) begin
        chk($sformatf("v%0d_text", v), 32'(ct), tbl[v].et);
        chk($sformatf("v%0d_audio", v), ca, tbl[v].ea);
        chk($sformatf("v%0d_text_ready", v), 32'(ctr), 32'(tbl[v].etr));
        chk($sformatf("v%0d_audio_ready", v), 32'(car), 32'(tbl[v].ear));
      end
    end
    // Latency from last rx_clock rise, then async reset during the delivery cycle
    for (int i = 0; i < tbl[0].n - 1; i++) beat(bq[i]);
    rise(bq[tbl[0].n - 1]);
    latency("deliver_latency");
    #1 rst = 1'b1;
    #1 chk("reset_in_deliver", {bus.frame_valid, bus.frame_error, bus.text_ready_out, bus.audio_ready_out,
                                 |bus.text_out, |bus.audio_out}, 0);
    bus.rx_pins = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    // Reset mid-payload: no error pulse, next frame still delivers
    b0 = nv;
    e0 = ne;
    beat(bq[0]);
    beat(bq[1]);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("reset_mid_payload", {bus.frame_valid, bus.frame_error}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < tbl[0].n; i++) beat(bq[i]);
    beat(17'h0);
    repeat (8) @(negedge clk);
    chk("after_reset_valid_count", nv - b0, 1);
    chk("after_reset_error_count", ne - e0, 0);
    chk("after_reset_audio", ca, tbl[0].ea);
    chk("after_reset_text", 32'(ct), tbl[0].et);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gpio_frame_receiver.md
GPIO_FRAME_RECEIVER -- requirements
Module: gpio_frame_receiver

Interface
REQ-001 Parameter DATA_W, default 16: data pin count per beat; SHALL satisfy DATA_W >= TEXT_W+2.
REQ-002 Parameter TEXT_W, default 8: text character width.
REQ-003 Parameter AUDIO_W, default 32: audio sample width; SHALL be an integer multiple of DATA_W; NBEATS = AUDIO_W/DATA_W.
REQ-004 Parameter SYNC_STAGES, default 2 (min 2): synchroniser depth on rx_pins.
REQ-005 FPGA_clock  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 rx_pins  in  DATA_W+2  bit DATA_W+1 = rx_clock, bit DATA_W = rx_valid, bits DATA_W-1:0 = data; asynchronous to FPGA_clock.
REQ-008 text_out  out  TEXT_W  received character, masked by text flag.
REQ-009 text_ready_out  out  1  text flag of delivered frame.
REQ-010 audio_out  out  AUDIO_W  received sample, masked by audio flag.
REQ-011 audio_ready_out  out  1  audio flag of delivered frame.
REQ-012 frame_valid  out  1  one-cycle strobe: frame delivered this cycle.
REQ-013 frame_error  out  1  one-cycle strobe: frame aborted or rejected.

Function
REQ-014 All rx_pins bits SHALL pass a SYNC_STAGES flop synchroniser; a beat SHALL be sampled on the FPGA_clock cycle a synchronised rx_clock 0->1 transition is detected.
REQ-015 States SHALL be IDLE, HEADER_DONE, PAYLOAD, CHECK (parity build only), DELIVER.
REQ-016 A frame SHALL start at a sampled beat where rx_valid=1 and rx_valid at the previous sampled beat was 0; that beat is the header: text flag = data[DATA_W-1], audio flag = data[DATA_W-2], text = data[TEXT_W-1:0].
REQ-017 The next NBEATS sampled beats SHALL fill audio most-significant slice first; beat counter counts 0..NBEATS-1, then the FSM goes to CHECK or DELIVER.
REQ-018 DELIVER SHALL last exactly one FPGA_clock cycle: frame_valid=1, text_out = text AND text flag, audio_out = audio AND audio flag, ready outputs = flags; then IDLE.
REQ-019 Outside DELIVER, text_out, audio_out, text_ready_out, audio_ready_out, frame_valid SHALL be 0.
REQ-020 Latency: outputs assert on the FPGA_clock cycle after the last payload beat (or parity beat) is sampled.
REQ-021 rx_valid=0 at any sampled beat during HEADER_DONE/PAYLOAD/CHECK SHALL abort to IDLE with a one-cycle frame_error pulse and no delivery.
REQ-022 A new valid rising edge mid-frame SHALL pulse frame_error, discard the partial frame, and treat that beat as a new header.
REQ-023 rx_valid held high after a frame SHALL NOT start another frame until it is seen low at a sampled beat.
REQ-024 frame_error and frame_valid SHALL never assert in the same cycle.

Reset
REQ-025 On reset assertion, the FSM SHALL enter IDLE immediately, synchroniser/previous-valid/edge flops and counters SHALL clear to 0, and every output SHALL be 0.
REQ-026 Reset mid-frame SHALL discard the partial frame without a frame_error pulse.

Configuration
REQ-027 Macro GPIO_RX_PARITY_EN defined: after the payload, one extra beat is sampled in CHECK; its data[0] SHALL equal even parity (XOR) of header flags, text and audio; mismatch SHALL pulse frame_error and skip DELIVER.
REQ-028 GPIO_RX_PARITY_EN undefined: no CHECK state, no parity beat; the frame is NBEATS+1 beats.

Structure
REQ-029 Package gpio_rx_pkg SHALL hold the state enum, flag bit offsets (text flag DATA_W-1, audio flag DATA_W-2), and rx_clock/rx_valid offsets relative to DATA_W.
REQ-030 Sub-module gpio_rx_sync SHALL implement the synchroniser and rx_clock rising-edge detector, outputting sampled data, rx_valid and a beat strobe.

Verification
REQ-031 Defaults, beats {0xC041, 0xDEAD, 0xBEEF} -> one frame_valid pulse, text_out=0x41, audio_out=0xDEADBEEF, both ready=1.
REQ-032 Header 0x8041 then 0x1234, 0x5678 -> text_out=0x41, audio_out=0, audio_ready_out=0.
REQ-033 rx_valid drops after first payload beat -> frame_error pulse, no frame_valid, outputs stay 0.
REQ-034 Reset asserted mid-payload -> all outputs 0 same cycle; next full frame delivers correctly.
REQ-035 GPIO_RX_PARITY_EN, DATA_W=8, AUDIO_W=32: correct parity beat -> delivery after 6 beats; flipped parity -> frame_error only.
